mul_pipe: RTL and testbench

MUL_PIPE -- requirements
Module: mul_pipe

---
 rtl/mul_pipe_pkg.sv | 18 +
 rtl/mul_pipe_stage.sv | 40 ++++
 rtl/mul_pipe_umul.sv | 10 +
 rtl/mul_pipe.sv | 103 ++++++++++
 tb/tb_mul_pipe.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pipe_pkg.sv
// Shared constants for the pipelined 32-bit multiplier: op encodings, XLEN and latency.
// MUL_PIPE_EXTRA_STAGE_EN selects the 3-cycle configuration.
package mul_pipe_pkg;
   localparam int XLEN = 32;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   localparam int LATENCY_BASE  = 2;
   localparam int LATENCY_EXTRA = 3;
`ifdef MUL_PIPE_EXTRA_STAGE_EN
   localparam int LATENCY = LATENCY_EXTRA;
`else
   localparam int LATENCY = LATENCY_BASE;
`endif
endpackage

// File: rtl/mul_pipe_stage.sv
// Generic valid/ready pipeline register with flush; loads when empty or draining this cycle.
module mul_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         vld_q;
   logic [W-1:0] data_q;

   // Depends only on local state, downstream ready and flush, never on in_valid.
   assign in_ready  = (!vld_q || out_ready) && !flush;
   assign out_valid = vld_q;
   assign out_data  = data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= 1'b0;
      end else if (flush) begin
         vld_q <= 1'b0;
      end else if (in_ready) begin
         vld_q <= in_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (in_valid && in_ready) begin
         data_q <= in_data;
      end
   end
endmodule

// File: rtl/mul_pipe_umul.sv
// Combinational unsigned 32x32->64 multiplier shared by the multiply datapaths.
module mul_pipe_umul
   import mul_pipe_pkg::*;
(
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [2*XLEN-1:0] p
);
   assign p = (2*XLEN)'(a) * (2*XLEN)'(b);
endmodule

// File: rtl/mul_pipe.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit: operand register, sign-magnitude multiply, result register.
// Defining MUL_PIPE_EXTRA_STAGE_EN registers the raw product before negate/select (latency 3).
module mul_pipe
   import mul_pipe_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int P1_W = 2 + 2*XLEN + TAG_W;
   localparam int P3_W = XLEN + TAG_W;

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic neg);
      // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
      return neg ? (~x + XLEN'(1)) : x;
   endfunction

   function automatic logic [XLEN-1:0] fix_result(input logic [2*XLEN-1:0] prod,
                                                  input logic neg, input logic [1:0] op);
      logic signed [2*XLEN-1:0] full;
      full = neg ? -$signed(prod) : $signed(prod);
      return (op == OP_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
   endfunction

   logic             vld_p1, rdy_p1;
   logic [P1_W-1:0]  data_p1;
   logic [1:0]       op_p1;
   logic [XLEN-1:0]  a_p1, b_p1;
   logic [TAG_W-1:0] tag_p1;
   logic             a_neg_p1, b_neg_p1, neg_p1;
   logic [2*XLEN-1:0] prod_p1;
   logic             vld_p3, in_vld_p3, in_rdy_p3;
   logic [P3_W-1:0]  in_data_p3, data_p3;

   // ---- stage 1: operands, op and tag
   mul_pipe_stage #(.W(P1_W)) u_stage_p1 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data({in_op, in_a, in_b, in_tag}),
      .out_valid(vld_p1), .out_ready(rdy_p1), .out_data(data_p1)
   );

   assign {op_p1, a_p1, b_p1, tag_p1} = data_p1;
   assign a_neg_p1 = (op_p1 == OP_MULH || op_p1 == OP_MULHSU) && a_p1[XLEN-1];
   assign b_neg_p1 = (op_p1 == OP_MULH) && b_p1[XLEN-1];
   assign neg_p1   = a_neg_p1 ^ b_neg_p1;

   mul_pipe_umul u_umul (
      .a(magnitude(a_p1, a_neg_p1)),
      .b(magnitude(b_p1, b_neg_p1)),
      .p(prod_p1)
   );

`ifdef MUL_PIPE_EXTRA_STAGE_EN
   localparam int P2_W = 2*XLEN + 1 + 2 + TAG_W;
   logic              vld_p2;
   logic [P2_W-1:0]   data_p2;
   logic [2*XLEN-1:0] prod_p2;
   logic              neg_p2;
   logic [1:0]        op_p2;
   logic [TAG_W-1:0]  tag_p2;

   // ---- stage 2: unsigned product, negate flag, op and tag
   mul_pipe_stage #(.W(P2_W)) u_stage_p2 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(vld_p1), .in_ready(rdy_p1), .in_data({prod_p1, neg_p1, op_p1, tag_p1}),
      .out_valid(vld_p2), .out_ready(in_rdy_p3), .out_data(data_p2)
   );

   assign {prod_p2, neg_p2, op_p2, tag_p2} = data_p2;
   assign in_vld_p3  = vld_p2;
   assign in_data_p3 = {fix_result(prod_p2, neg_p2, op_p2), tag_p2};
   assign busy       = vld_p1 || vld_p2 || vld_p3;
`else
   assign rdy_p1     = in_rdy_p3;
   assign in_vld_p3  = vld_p1;
   assign in_data_p3 = {fix_result(prod_p1, neg_p1, op_p1), tag_p1};
   assign busy       = vld_p1 || vld_p3;
`endif

   // ---- output stage: 32-bit result and tag
   mul_pipe_stage #(.W(P3_W)) u_stage_p3 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_vld_p3), .in_ready(in_rdy_p3), .in_data(in_data_p3),
      .out_valid(vld_p3), .out_ready(out_ready), .out_data(data_p3)
   );

   // A result sitting in the output stage during a flush is discarded, not handed off.
   assign out_valid = vld_p3 && !flush;
   assign {out_result, out_tag} = data_p3;
endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: randomized and directed operations against a wide-arithmetic model.
module tb_mul_pipe;
   import mul_pipe_pkg::*;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_a, in_b;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid, out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   mul_pipe #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      int               cyc;
      bit               chk_lat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   seen_front = 0;
   bit   bp_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: sign/zero-extend to 128 bits and multiply exactly.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [127:0] ea, eb, p;
      ea = (op == OP_MULH || op == OP_MULHSU) ? {{96{a[31]}}, a} : {96'd0, a};
      eb = (op == OP_MULH) ? {{96{b[31]}}, b} : {96'd0, b};
      p  = ea * eb;
      return (op == OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Offer one operation starting at posedge+1; returns at posedge+1 after it is accepted.
   task automatic offer(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp_res, input bit lat);
      exp_t e;
      bit   done = 0;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.res = exp_res; e.tag = tag; e.cyc = cyc + LATENCY; e.chk_lat = lat;
            q.push_back(e);
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) chk("accept_timeout", 64'(done), 64'(1));
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 300 && q.size() != 0; t++) @(posedge clk);
      #1;
      chk("drain_empty", 64'(q.size()), 64'(0));
   endtask

   task automatic clear_expect();
      q.delete();
      seen_front = 0;
   endtask

   // Monitor: compare the front expectation every cycle a result is presented.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
               chk("result", 64'(out_result), 64'(q[0].res));
               chk("tag", 64'(out_tag), 64'(q[0].tag));
               if (q[0].chk_lat && !seen_front) chk("latency", 64'(cyc), 64'(q[0].cyc));
               seen_front = 1;
               if (out_ready) begin
                  void'(q.pop_front());
                  seen_front = 0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      int idx;
      logic [31:0] ra [4];
      logic [31:0] rb [4];
      logic [1:0]  rop;
      logic [31:0] va, vb;

      rst = 1'b1; in_valid = 1'b0; in_op = OP_MUL; in_a = '0; in_b = '0; in_tag = '0;
      flush = 1'b0; out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_out_result", 64'(out_result), 64'(0));
      chk("rst_out_tag", 64'(out_tag), 64'(0));
      @(negedge clk); rst = 1'b0;
      #1 chk("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      // Directed arithmetic corners, pipeline empty so latency is exact
      offer(OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1); wait_drain();
      offer(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 1); wait_drain();
      offer(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1); wait_drain();
      offer(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4, 32'hFFFF_FFFF, 1); wait_drain();
      offer(OP_MULHU,  32'hFFFF_FFFF, 32'd2,         5'd5, 32'h0000_0001, 1); wait_drain();
      offer(OP_MULH,   32'h8000_0000, 32'h7FFF_FFFF, 5'd6, 32'hC000_0000, 1); wait_drain();

      // Backpressure: tags 1..4 offered back to back with the output stalled
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
      idx = 0;
      in_valid = 1'b1; in_op = OP_MULH; in_a = ra[0]; in_b = rb[0]; in_tag = 5'd1;
      repeat (8) begin
         @(negedge clk);
         if (in_ready && idx < 4) begin
            q.push_back('{res: ref_mul(OP_MULH, ra[idx], rb[idx]), tag: TAG_W'(idx + 1),
                          cyc: 0, chk_lat: 1'b0});
            idx++;
         end
         @(posedge clk); #1;
         if (idx < 4) begin
            in_a = ra[idx]; in_b = rb[idx]; in_tag = TAG_W'(idx + 1);
         end
      end
      chk("bp_accept_count", 64'(idx), 64'(LATENCY));
      chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = idx; i < 4; i++)
         offer(OP_MULH, ra[i], rb[i], TAG_W'(i + 1), ref_mul(OP_MULH, ra[i], rb[i]), 0);
      wait_drain();

      // Flush with two operations in flight and a new one offered
      offer(OP_MUL, 32'd3, 32'd5, 5'd10, 32'd15, 0);
      offer(OP_MUL, 32'd4, 32'd6, 5'd11, 32'd24, 0);
      in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd12;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready), 64'(0));
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      clear_expect();
      chk("flush_busy", 64'(busy), 64'(0));
      chk("flush_out_valid_after", 64'(out_valid), 64'(0));
      repeat (6) @(posedge clk);
      #1;
      offer(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13,
            ref_mul(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1);
      wait_drain();

      // Asynchronous reset mid-operation
      offer(OP_MUL, 32'd100, 32'd200, 5'd20, 32'd20000, 0);
      offer(OP_MUL, 32'd300, 32'd400, 5'd21, 32'd120000, 0);
      #3 rst = 1'b1;
      #1;
      chk("amid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("amid_rst_busy", 64'(busy), 64'(0));
      chk("amid_rst_out_result", 64'(out_result), 64'(0));
      clear_expect();
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1 chk("post_rst_in_ready", 64'(in_ready), 64'(1));
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_busy", 64'(busy), 64'(0));

      // Randomized traffic with random output backpressure
      bp_mode = 1;
      for (int n = 0; n < 300; n++) begin
         rop = 2'($urandom_range(0, 3));
         va = pick_val();
         vb = pick_val();
         offer(rop, va, vb, TAG_W'(n), ref_mul(rop, va, vb), 0);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end
      bp_mode = 0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain();
      chk("final_busy", 64'(busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
